// File: rtl/wave_gen_if.sv
// Config and waveform-output bundle for wave_gen. The master drives run enable and config
// writes; the slave (wave_gen) returns the sample, direction and event pulses.
interface wave_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [15:0]      cfg_wdata;
  logic [WIDTH-1:0] value;
  logic             dir;
  logic             step;
  logic             wrap;
  logic             cfg_err;

  modport master (
    output en, cfg_we, cfg_addr, cfg_wdata,
    input  value, dir, step, wrap, cfg_err
  );

  modport slave (
    input  en, cfg_we, cfg_addr, cfg_wdata,
    output value, dir, step, wrap, cfg_err
  );
endinterface

// File: rtl/wave_gen.sv
// Programmable stepped-waveform generator: triangle, saw up, saw down and square between
// programmable limits, advanced by a prescaler that fires every DIV+1 enabled cycles.
module wave_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input logic       clk,
  input logic       reset,
  wave_gen_if.slave bus
);
  localparam logic [1:0] ModeTri    = 2'd0;
  localparam logic [1:0] ModeSawUp  = 2'd1;
  localparam logic [1:0] ModeSawDn  = 2'd2;
  localparam logic [1:0] ModeSquare = 2'd3;

  localparam logic [1:0] AddrLimL = 2'd0;
  localparam logic [1:0] AddrLimH = 2'd1;
  localparam logic [1:0] AddrMode = 2'd2;
  localparam logic [1:0] AddrDiv  = 2'd3;

  logic [WIDTH-1:0] lim_l_q, lim_h_q, value_q, value_d, wr_lim;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q, cnt_q, cnt_d;
  logic             dir_q, dir_d, wrap_d, going_up;
  logic             step_q, wrap_q, cfg_err_q;
  logic             step_ev, wr_l, wr_h, bad_l, bad_h;

  assign wr_lim  = bus.cfg_wdata[WIDTH-1:0];
  assign wr_l    = bus.cfg_we && (bus.cfg_addr == AddrLimL);
  assign wr_h    = bus.cfg_we && (bus.cfg_addr == AddrLimH);
  assign bad_l   = wr_l && (wr_lim > lim_h_q);
  assign bad_h   = wr_h && (wr_lim < lim_l_q);
  assign step_ev = bus.en && (cnt_q == div_q);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!bus.en || step_ev || (bus.cfg_we && (bus.cfg_addr == AddrDiv))) begin
      cnt_d = '0;
    end
  end

  // Next sample for a step event; range recovery overrides every mode.
  always_comb begin
    value_d  = value_q;
    dir_d    = dir_q;
    wrap_d   = 1'b0;
    going_up = 1'b0;
    if (value_q > lim_h_q) begin
      value_d = lim_h_q;
      dir_d   = 1'b0;
    end else if (value_q < lim_l_q) begin
      value_d = lim_l_q;
      dir_d   = 1'b1;
    end else begin
      case (mode_q)
        ModeTri: begin
          if (lim_l_q == lim_h_q) begin
            dir_d  = 1'b1;
            wrap_d = 1'b1;
          end else begin
            // At a limit the direction is implied by the limit, not by the stored dir.
            going_up = (value_q == lim_l_q) || ((value_q != lim_h_q) && dir_q);
            if (going_up) begin
              value_d = value_q + WIDTH'(1);
              dir_d   = (value_d != lim_h_q);
            end else begin
              value_d = value_q - WIDTH'(1);
              dir_d   = (value_d == lim_l_q);
              wrap_d  = dir_d;
            end
          end
        end
        ModeSawUp: begin
          dir_d = 1'b1;
          if (value_q == lim_h_q) begin
            value_d = lim_l_q;
            wrap_d  = 1'b1;
          end else begin
            value_d = value_q + WIDTH'(1);
          end
        end
        ModeSawDn: begin
          dir_d = 1'b0;
          if (value_q == lim_l_q) begin
            value_d = lim_h_q;
            wrap_d  = 1'b1;
          end else begin
            value_d = value_q - WIDTH'(1);
          end
        end
        ModeSquare: begin
          if (value_q == lim_h_q) begin
            value_d = lim_l_q;
            wrap_d  = 1'b1;
          end else begin
            value_d = lim_h_q;
          end
          dir_d = (value_d == lim_l_q);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lim_l_q   <= '0;
      lim_h_q   <= WIDTH'(9);
      mode_q    <= ModeTri;
      div_q     <= '0;
      cnt_q     <= '0;
      value_q   <= '0;
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      step_q    <= step_ev;
      wrap_q    <= step_ev && wrap_d;
      cfg_err_q <= bad_l || bad_h;
      if (step_ev) begin
        value_q <= value_d;
        dir_q   <= dir_d;
      end
      if (wr_l && !bad_l) lim_l_q <= wr_lim;
      if (wr_h && !bad_h) lim_h_q <= wr_lim;
      if (bus.cfg_we && (bus.cfg_addr == AddrMode)) mode_q <= bus.cfg_wdata[1:0];
      if (bus.cfg_we && (bus.cfg_addr == AddrDiv))  div_q  <= bus.cfg_wdata[DIV_W-1:0];
    end
  end

  assign bus.value   = value_q;
  assign bus.dir     = dir_q;
  assign bus.step    = step_q;
  assign bus.wrap    = wrap_q;
  assign bus.cfg_err = cfg_err_q;
endmodule
